// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner: synchronises N_CH pad inputs, optionally glitch-filters them,
// emits one-cycle rise/fall pulses and produces a synchronised core reset.  Rev 1.0
`default_nettype none

module pad_input_conditioner #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_LEN    = 4,
  parameter logic [N_CH-1:0] RST_VAL     = {N_CH{1'b0}},
  parameter int              RST_STAGES  = 3
) (
  input  logic            i_CLK,
  input  logic            i_RSTN,
  input  logic [N_CH-1:0] i_IN,
  input  logic [N_CH-1:0] i_FILT_EN,
  output logic [N_CH-1:0] o_OUT,
  output logic [N_CH-1:0] o_RISE,
  output logic [N_CH-1:0] o_FALL,
  output logic            o_RSTN
);

  // A one-bit counter is kept for FILT_LEN=1 so the vector never collapses to zero width.
  localparam int               CNT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   out_q;
    logic                   out_next;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
        sync_q <= {SYNC_STAGES{RST_VAL[ch]}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i_IN[ch]};
      end
    end

    always_comb begin
      out_next = out_q;
      cnt_next = '0;
      if (!i_FILT_EN[ch]) begin
        out_next = s;
      end else if (s != out_q) begin
        if (cnt == CNT_MAX) begin
          out_next = s;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    end

    // Pulses are derived from the next level so they line up with the o_OUT change.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
        out_q  <= RST_VAL[ch];
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        out_q  <= out_next;
        cnt    <= cnt_next;
        rise_q <= out_next & ~out_q;
        fall_q <= ~out_next & out_q;
      end
    end

    assign o_OUT[ch]  = out_q;
    assign o_RISE[ch] = rise_q;
    assign o_FALL[ch] = fall_q;
  end : g_ch

  logic [RST_STAGES-1:0] rst_sr;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      rst_sr <= '0;
    end else begin
      rst_sr <= {rst_sr[RST_STAGES-2:0], 1'b1};
    end
  end

  assign o_RSTN = rst_sr[RST_STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_pad_input_conditioner.sv
// tb_pad_input_conditioner: table vectors, hand-written reset sequences and a
// randomised run against a history-based reference model.  Rev 1.0
`default_nettype none

module tb_pad_input_conditioner;

  localparam int              N_CH        = 4;
  localparam int              SYNC_STAGES = 2;
  localparam int              FILT_LEN    = 4;
  localparam logic [N_CH-1:0] RST_VAL     = 4'b0000;
  localparam int              RST_STAGES  = 3;
  localparam int              HIST        = 4096;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] pad_in;
  logic [N_CH-1:0] filt_en;
  logic [N_CH-1:0] out_lvl;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            core_rstn;

  int total = 0;
  int bad   = 0;

  pad_input_conditioner #(
    .N_CH       (N_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .RST_VAL    (RST_VAL),
    .RST_STAGES (RST_STAGES)
  ) dut (
    .i_CLK    (clk),
    .i_RSTN   (rst_n),
    .i_IN     (pad_in),
    .i_FILT_EN(filt_en),
    .o_OUT    (out_lvl),
    .o_RISE   (rise),
    .o_FALL   (fall),
    .o_RSTN   (core_rstn)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the full history of sampled pads and modes since the
  // last reset. A filtered output flips only when the last FILT_LEN edges, all
  // after the previous output change, were filtered and saw s differ from the output.
  logic pad_h [N_CH][HIST];
  logic fen_h [N_CH][HIST];
  int   last_upd [N_CH];
  int   mt;
  logic [N_CH-1:0] m_out, m_rise, m_fall;

  function automatic logic model_s(input int ch, input int t);
    if (t >= SYNC_STAGES) return pad_h[ch][t-SYNC_STAGES];
    return RST_VAL[ch];
  endfunction

  task automatic model_reset();
    mt     = 0;
    m_out  = RST_VAL;
    m_rise = '0;
    m_fall = '0;
    for (int ch = 0; ch < N_CH; ch++) last_upd[ch] = -1;
  endtask

  task automatic model_edge(input logic [N_CH-1:0] pad, input logic [N_CH-1:0] fen);
    logic prev, s, ok;
    for (int ch = 0; ch < N_CH; ch++) begin
      pad_h[ch][mt] = pad[ch];
      fen_h[ch][mt] = fen[ch];
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      prev = m_out[ch];
      s    = model_s(ch, mt);
      if (!fen[ch]) begin
        if (s != prev) begin
          m_out[ch]    = s;
          last_upd[ch] = mt;
        end
      end else begin
        ok = 1'b1;
        for (int k = 0; k < FILT_LEN; k++) begin
          if ((mt - k) < 0 || (mt - k) <= last_upd[ch]) ok = 1'b0;
          else if (!fen_h[ch][mt-k] || model_s(ch, mt - k) == prev) ok = 1'b0;
        end
        if (ok) begin
          m_out[ch]    = s;
          last_upd[ch] = mt;
        end
      end
      m_rise[ch] = m_out[ch] & ~prev;
      m_fall[ch] = ~m_out[ch] & prev;
    end
    mt++;
  endtask

  task automatic step(input logic [N_CH-1:0] pad, input logic [N_CH-1:0] fen);
    pad_in  = pad;
    filt_en = fen;
    @(posedge clk);
    model_edge(pad, fen);
    @(negedge clk);
    chk("rnd_out",  32'(out_lvl),   32'(m_out));
    chk("rnd_rise", 32'(rise),      32'(m_rise));
    chk("rnd_fall", 32'(fall),      32'(m_fall));
    chk("rnd_rstn", 32'(core_rstn), 32'(mt >= RST_STAGES));
  endtask

  typedef struct {
    logic [N_CH-1:0] in;
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
  } vec_t;

  vec_t tbl [30];

  initial begin
    logic [N_CH-1:0] pad, fen;

    // ch0/ch1/ch3 filtered, ch2 bypassed; index k = value sampled at edge Ek
    // and outputs expected after that edge.
    tbl[0]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0011, 4'b0100, 4'b0100, 4'b0000};
    tbl[3]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0100};
    tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[6]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0001, 4'b0011, 4'b0010, 4'b0000};
    tbl[14] = '{4'b0001, 4'b0011, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0001, 4'b0011, 4'b0000, 4'b0000};
    tbl[16] = '{4'b0001, 4'b0011, 4'b0000, 4'b0000};
    tbl[17] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010};
    tbl[18] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[19] = '{4'b1001, 4'b0001, 4'b0000, 4'b0000};
    tbl[20] = '{4'b1001, 4'b0001, 4'b0000, 4'b0000};
    tbl[21] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[22] = '{4'b1001, 4'b0001, 4'b0000, 4'b0000};
    tbl[23] = '{4'b1001, 4'b0001, 4'b0000, 4'b0000};
    tbl[24] = '{4'b1001, 4'b0001, 4'b0000, 4'b0000};
    tbl[25] = '{4'b1001, 4'b0001, 4'b0000, 4'b0000};
    tbl[26] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[27] = '{4'b0001, 4'b1001, 4'b1000, 4'b0000};
    tbl[28] = '{4'b0001, 4'b1001, 4'b0000, 4'b0000};
    tbl[29] = '{4'b0001, 4'b1001, 4'b0000, 4'b0000};

    rst_n   = 1'b0;
    pad_in  = '0;
    filt_en = '0;
    model_reset();
    #12;
    chk("reset_out",  32'(out_lvl),   32'(RST_VAL));
    chk("reset_rise", 32'(rise),      32'h0);
    chk("reset_fall", 32'(fall),      32'h0);
    chk("reset_rstn", 32'(core_rstn), 32'h0);

    @(negedge clk);
    rst_n   = 1'b1;
    filt_en = 4'b1011;
    for (int k = 0; k < 30; k++) begin
      pad_in = tbl[k].in;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out", k),  32'(out_lvl), 32'(tbl[k].out));
      chk($sformatf("vec%0d_rise", k), 32'(rise),    32'(tbl[k].rise));
      chk($sformatf("vec%0d_fall", k), 32'(fall),    32'(tbl[k].fall));
      chk($sformatf("vec%0d_rstn", k), 32'(core_rstn), 32'(k >= RST_STAGES - 1));
    end

    // Reset while ch3 is counting back down: levels drop with no fall pulse.
    rst_n = 1'b0;
    #1;
    chk("midrst_out",  32'(out_lvl),   32'(RST_VAL));
    chk("midrst_fall", 32'(fall),      32'h0);
    chk("midrst_rise", 32'(rise),      32'h0);
    chk("midrst_rstn", 32'(core_rstn), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_hold_out",  32'(out_lvl), 32'(RST_VAL));
    chk("midrst_hold_fall", 32'(fall),    32'h0);

    // Release with ch0 still high: the model expects a normal filtered rise.
    rst_n = 1'b1;
    model_reset();
    pad = pad_in;
    fen = 4'($urandom);
    for (int c = 0; c < 40; c++) begin
      step(pad, fen);
      pad ^= 4'($urandom) & 4'($urandom);
    end

    // Short low glitch on the raw reset between clock edges.
    #1;
    rst_n = 1'b0;
    #1;
    chk("glitch_rstn", 32'(core_rstn), 32'h0);
    chk("glitch_out",  32'(out_lvl),   32'(RST_VAL));
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 300; c++) begin
      step(pad, fen);
      pad ^= 4'($urandom) & 4'($urandom);
    end

    // Flip every channel's mode mid-stream without a reset.
    fen = ~fen;
    for (int c = 0; c < 300; c++) begin
      step(pad, fen);
      pad ^= 4'($urandom) & 4'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pad_input_conditioner.md
Name: pad_input_conditioner

Overview:
Parametrised conditioning stage between the pad ring's input-pad Y outputs and the core.
- Synchronises N_CH asynchronous pad inputs (e.g. UART_RXD, ADS1292_DRDY, MISO).
- Optionally glitch-filters each channel and emits one-cycle rise/fall pulses.
- Generates a synchronised, glitch-restarting core reset.
- Generalises the single-channel reset synchroniser to many channels, with per-channel filter/bypass mode.

Parameters:
N_CH, 4, number of conditioned input channels (>=1)
SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2)
FILT_LEN, 4, consecutive differing samples required before a filtered output changes (>=1)
RST_VAL, {N_CH{1'b0}}, per-channel reset value of sync chain, o_OUT and filter state (N_CH bits)
RST_STAGES, 3, i_CLK edges with i_RSTN high before o_RSTN releases (>=2)

Ports:
i_CLK  input  1  single system clock; all logic on rising edge
i_RSTN  input  1  asynchronous active-low reset; resets every register in the block
i_IN  input  N_CH  raw asynchronous pad inputs
i_FILT_EN  input  N_CH  per channel: 1 = glitch filter active, 0 = bypass (synchronise only); quasi-static
o_OUT  output  N_CH  conditioned level
o_RISE  output  N_CH  one-cycle pulse, asserted in the cycle o_OUT[i] becomes 1
o_FALL  output  N_CH  one-cycle pulse, asserted in the cycle o_OUT[i] becomes 0
o_RSTN  output  1  core reset: asserts asynchronously, deasserts synchronously

Behaviour:
- Reset (i_RSTN=0, asynchronous):
  - sync chains and o_OUT = RST_VAL; filter counters = 0
  - o_RISE = o_FALL = 0; o_RSTN = 0 immediately
  - no edge pulses are generated on reset entry or exit
- Synchroniser: per channel, a SYNC_STAGES-deep shift register; s[i] = last stage. No logic between stages.
- Filtered mode (i_FILT_EN[i]=1), per-channel counter cnt of width $clog2(FILT_LEN), evaluated at each edge:
  - s[i]==o_OUT[i]: cnt <= 0.
  - s[i]!=o_OUT[i] and cnt<FILT_LEN-1: cnt <= cnt+1.
  - s[i]!=o_OUT[i] and cnt==FILT_LEN-1: o_OUT[i] <= s[i]; cnt <= 0.
  - FILT_LEN=1 degenerates to bypass timing.
  - Latency: input stable from sampling edge E0 → o_OUT updates at edge E(SYNC_STAGES+FILT_LEN-1).
  - Any pulse shorter than FILT_LEN synchronised samples is fully rejected, with no output activity.
- Bypass mode (i_FILT_EN[i]=0):
  - o_OUT[i] <= s[i] every edge; cnt held at 0.
  - Latency SYNC_STAGES edges from E0 (update at E(SYNC_STAGES)).
- Mode change mid-count: counter clears while bypassed. Switching 1→0 lets o_OUT follow s on the next edge, with normal edge pulses.
- Edge pulses are registered and updated on the same edge as o_OUT:
  - o_RISE[i] = 1 for exactly one cycle when o_OUT[i] goes 0→1.
  - o_FALL[i] = 1 for exactly one cycle when o_OUT[i] goes 1→0.
  - Never both high. Channels are fully independent.
- Reset generator:
  - RST_STAGES-bit shift register, cleared asynchronously by i_RSTN and shifting in 1; o_RSTN = last bit.
  - o_RSTN rises on the RST_STAGES-th rising edge after i_RSTN deassertion.
  - Any i_RSTN low pulse, however short, re-asserts o_RSTN asynchronously and restarts the count.
- The block's own registers use raw i_RSTN, not o_RSTN.
- Reset mid-operation: all channel state returns to RST_VAL within the reset assertion, with no pulses. After release, a channel whose input differs from RST_VAL produces a normal (filtered or bypassed) transition and pulse.

Test Plan:
- Reset release, defaults:
  - i_RSTN 0→1 before edge E0 → o_RSTN rises at E2.
  - i_RSTN 1-ns low glitch at E1 → o_RSTN falls immediately, then rises 3 edges after the glitch ends.
- Filtered step: ch0 FILT_EN=1, i_IN[0] 0→1 sampled at E0 and held → o_OUT[0]=1 and o_RISE[0]=1 at E5 only; o_RISE[0]=0 at E6.
- Glitch rejection: ch1 FILT_EN=1, i_IN[1] high for exactly 3 cycles → o_OUT[1], o_RISE[1], o_FALL[1] stay 0 throughout. Same stimulus held 4 cycles → o_OUT[1] rises.
- Bypass: ch2 FILT_EN=0, 1-cycle high pulse on i_IN[2] sampled at E0 → o_OUT[2]=1 at E2, 0 at E3; o_RISE[2] at E2, o_FALL[2] at E3.
- Mid-count disturbance: ch3 FILT_EN=1, i_IN[3] high 2 cycles, low 1, high 4 → only the final 4-cycle run produces a rise.
  - Then pull i_RSTN low mid-count → o_OUT=RST_VAL, no o_FALL pulse.
- Independence: drive all 4 channels with distinct random patterns, mixed FILT_EN → per-channel outputs match a reference model every cycle.
